alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- 8-bit datapath ALU for the small LC-style processor.
- Performs ADD, AND, NOT and PASS on operands chosen from register sources, the 5-/6-bit instruction immediate, or the 6-bit PC.
- Produces the result plus N/Z/P condition flags for the register file and the branch unit.
- Result and flags are registered: one-cycle latency.

Parameters:
- WIDTH, 8, datapath width. Only 8 is supported; widths of imm/pc fields are fixed.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- alu_op  input  3  operation select
- source_sel  input  3  operand source select
- ins_immediate  input  6  immediate field of the instruction
- pc  input  6  current program counter
- reg_sr1_out  input  8  source register 1 value
- reg_sr2_out  input  8  source register 2 value
- result  output  8  registered ALU result
- negative  output  1  registered: result[7]==1
- zero  output  1  registered: result==0
- positive  output  1  registered: result nonzero and result[7]==0

Behaviour:
- Reset: one clock, synchronous, active-low. On a rising clk with rst_n=0: result=8'h00, zero=1, negative=0, positive=0. Reset overrides any operation in that cycle.
- Outputs update only on the rising clk edge. Inputs sampled at edge N appear on the outputs after edge N. No enable and no handshake: a new result is produced every cycle.
- imm5 = sign-extend ins_immediate[4:0] to 8 bits.
- imm6 = sign-extend ins_immediate[5:0] to 8 bits.
- pc8 = zero-extend pc to 8 bits.
- Operand select (A, B):
  - source_sel=0 (immediate): A=reg_sr1_out, B=imm5.
  - source_sel=1 (PC-relative): A=pc8, B=imm6.
  - source_sel=2 (register): A=reg_sr1_out, B=reg_sr2_out.
  - source_sel=3..7 (reserved): A=reg_sr1_out, B=8'h00.
- Operations:
  - alu_op=0 ADD: A+B, modulo 256. Carry/overflow are discarded; no carry flag.
  - alu_op=1 AND: A & B.
  - alu_op=2 NOT: with source_sel=2, result is ~reg_sr1_out; otherwise ~B. So NOTI with source_sel=0 gives ~imm5.
  - alu_op=3 PASS: result is B (load immediate / move).
  - alu_op=4..7 reserved: result 8'h00.
- Flags: derived from the new result in the same register update. Exactly one of negative/zero/positive is high at all times, including after reset. Reserved ops therefore give zero=1.
- Fully combinational next-state, no internal state beyond the output registers. X-free: every select/op combination has a defined result.

Test Plan:
- Reset: hold rst_n=0 for one edge with arbitrary inputs -> result=0x00, zero=1, negative=0, positive=0. Release rst_n -> the next edge loads the computed value.
- ADDI: op=0, sel=0, imm=6'b010100 (imm5=-12), sr1=52, sr2=74 -> after one edge result=0x28, P=1.
- ADD then LEA: op=0, sel=2, sr1=0x34, sr2=0x4A -> result=0x7E, P=1. Then op=0, sel=1, pc=6'b011100, imm=6'b010100 -> result=0x30 (28+20), P=1.
- NOT and NOTI: op=2, sel=2, sr1=0x34, sr2=0x4A -> result=0xCB, N=1. Then op=2, sel=0, imm=6'b010100 -> result=0x0B, P=1.
- AND and ANDI: op=1, sel=2, sr1=0x34, sr2=0x4A -> result=0x00, Z=1. Then op=1, sel=0, imm=6'b010100 -> result=0x34, P=1.
- Wrap and reserved codes, back-to-back one per cycle:
  - op=0, sel=2, sr1=0xFF, sr2=0x01 -> result=0x00, Z=1.
  - op=5 -> result=0x00, Z=1.
  - op=3, sel=3 -> result=0x00.
  - op=3, sel=0, imm=6'b011111 -> result=0xFF, N=1.

Source files
------------

// File: rtl/alu_core_if.sv
// Operand/op bus into the datapath ALU and the registered result/flags back out.
interface alu_core_if #(parameter int WIDTH = 8);
    logic [2:0]       alu_op;
    logic [2:0]       source_sel;
    logic [5:0]       ins_immediate;
    logic [5:0]       pc;
    logic [WIDTH-1:0] reg_sr1_out;
    logic [WIDTH-1:0] reg_sr2_out;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             positive;

    modport master (
        output alu_op, source_sel, ins_immediate, pc, reg_sr1_out, reg_sr2_out,
        input  result, negative, zero, positive
    );
    modport slave (
        input  alu_op, source_sel, ins_immediate, pc, reg_sr1_out, reg_sr2_out,
        output result, negative, zero, positive
    );
endinterface

// File: rtl/alu_core.sv
// 8-bit LC-style ALU: ADD/AND/NOT/PASS over reg, imm or PC operands,
// result and N/Z/P flags registered with one-cycle latency.
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_core_if.slave   bus
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_PASS = 3'd3;

    localparam logic [2:0] SEL_IMM = 3'd0;
    localparam logic [2:0] SEL_PC  = 3'd1;
    localparam logic [2:0] SEL_REG = 3'd2;

    logic [WIDTH-1:0] imm5, imm6, pc8;
    logic [WIDTH-1:0] op_a, op_b, res_d;
    logic [WIDTH-1:0] result_q;
    logic             neg_q, zero_q, pos_q;

    assign imm5 = {{(WIDTH-5){bus.ins_immediate[4]}}, bus.ins_immediate[4:0]};
    assign imm6 = {{(WIDTH-6){bus.ins_immediate[5]}}, bus.ins_immediate[5:0]};
    assign pc8  = {{(WIDTH-6){1'b0}}, bus.pc};

    always_comb begin
        op_a = bus.reg_sr1_out;
        op_b = '0;
        case (bus.source_sel)
            SEL_IMM: op_b = imm5;
            SEL_PC:  begin op_a = pc8; op_b = imm6; end
            SEL_REG: op_b = bus.reg_sr2_out;
            default: op_b = '0;
        endcase
    end

    always_comb begin
        res_d = '0;
        case (bus.alu_op)
            OP_ADD:  res_d = op_a + op_b;
            OP_AND:  res_d = op_a & op_b;
            // Register-form NOT inverts SR1; every other source inverts B (NOTI gives ~imm5).
            OP_NOT:  res_d = (bus.source_sel == SEL_REG) ? ~bus.reg_sr1_out : ~op_b;
            OP_PASS: res_d = op_b;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b1;
            pos_q    <= 1'b0;
        end else begin
            result_q <= res_d;
            neg_q    <= res_d[WIDTH-1];
            zero_q   <= (res_d == '0);
            pos_q    <= !res_d[WIDTH-1] && (res_d != '0);
        end
    end

    assign bus.result   = result_q;
    assign bus.negative = neg_q;
    assign bus.zero     = zero_q;
    assign bus.positive = pos_q;
endmodule

// File: tb/tb_alu_core.sv
// Directed plus random checks of alu_core against an integer reference model.
module tb_alu_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_core_if bus();
    alu_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int sext(input int v, input int bits);
        int m;
        m = v % (1 << bits);
        return (m >= (1 << (bits - 1))) ? m - (1 << bits) : m;
    endfunction

    function automatic int model(input int op, input int sel, input int imm,
                                 input int pcv, input int s1, input int s2);
        int a, b;
        a = s1;
        case (sel)
            0: b = sext(imm, 5);
            1: begin a = pcv; b = sext(imm, 6); end
            2: b = s2;
            default: b = 0;
        endcase
        b = (b + 256) % 256;
        case (op)
            0: return (a + b) % 256;
            1: return a & b;
            2: return 255 - ((sel == 2) ? s1 : b);
            3: return b;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input int op, input int sel, input int imm,
                         input int pcv, input int s1, input int s2);
        bus.alu_op        = 3'(op);
        bus.source_sel    = 3'(sel);
        bus.ins_immediate = 6'(imm);
        bus.pc            = 6'(pcv);
        bus.reg_sr1_out   = 8'(s1);
        bus.reg_sr2_out   = 8'(s2);
    endtask

    task automatic check_out(input string tag, input int exp);
        logic [7:0] e;
        e = 8'(exp);
        checks++;
        assert (bus.result === e) else begin
            errors++;
            $error("FAIL %s result got=%h exp=%h", tag, bus.result, e);
        end
        checks++;
        assert (bus.negative === (exp >= 128)) else begin
            errors++;
            $error("FAIL %s negative got=%b exp=%b", tag, bus.negative, exp >= 128);
        end
        checks++;
        assert (bus.zero === (exp == 0)) else begin
            errors++;
            $error("FAIL %s zero got=%b exp=%b", tag, bus.zero, exp == 0);
        end
        checks++;
        assert (bus.positive === (exp > 0 && exp < 128)) else begin
            errors++;
            $error("FAIL %s positive got=%b exp=%b", tag, bus.positive, exp > 0 && exp < 128);
        end
    endtask

    // Applies one operation, clocks it, and checks against both the model and
    // the hand-derived value.
    task automatic step(input string tag, input int op, input int sel, input int imm,
                        input int pcv, input int s1, input int s2, input int lit);
        int m;
        drive(op, sel, imm, pcv, s1, s2);
        m = model(op, sel, imm, pcv, s1, s2);
        @(posedge clk); #1;
        check_out(tag, m);
        checks++;
        assert (bus.result === 8'(lit)) else begin
            errors++;
            $error("FAIL %s literal got=%h exp=%h", tag, bus.result, 8'(lit));
        end
    endtask

    initial begin
        int op, sel, imm, pcv, s1, s2, m;
        drive(0, 2, 6'h15, 6'h3F, 8'hA5, 8'h5A);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_out("reset", 0);
        rst_n = 1'b1;

        step("addi",  0, 0, 6'b010100, 0,         52,    74,    8'h28);
        step("add",   0, 2, 0,         0,         8'h34, 8'h4A, 8'h7E);
        step("lea",   0, 1, 6'b010100, 6'b011100, 8'h34, 8'h4A, 8'h30);
        step("not",   2, 2, 0,         0,         8'h34, 8'h4A, 8'hCB);
        step("noti",  2, 0, 6'b010100, 0,         8'h34, 8'h4A, 8'h0B);
        step("and",   1, 2, 0,         0,         8'h34, 8'h4A, 8'h00);
        step("andi",  1, 0, 6'b010100, 0,         8'h34, 8'h4A, 8'h34);
        step("wrap",  0, 2, 0,         0,         8'hFF, 8'h01, 8'h00);
        step("rsvop", 5, 2, 0,         0,         8'hFF, 8'h01, 8'h00);
        step("rsvsel",3, 3, 6'h3F,     6'h3F,     8'h77, 8'h66, 8'h00);
        step("passi", 3, 0, 6'b011111, 0,         8'h34, 8'h4A, 8'hFF);
        step("lea_neg",0,1, 6'b100000, 6'd5,      0,     0,     8'hE5);

        // Reset mid-stream must win over a live operation.
        drive(0, 2, 0, 0, 8'h10, 8'h20);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_out("reset2", 0);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            op  = int'($urandom_range(7, 0));
            sel = int'($urandom_range(7, 0));
            imm = int'($urandom_range(63, 0));
            pcv = int'($urandom_range(63, 0));
            s1  = int'($urandom_range(255, 0));
            s2  = int'($urandom_range(255, 0));
            drive(op, sel, imm, pcv, s1, s2);
            m = model(op, sel, imm, pcv, s1, s2);
            @(posedge clk); #1;
            check_out($sformatf("rand%0d op%0d sel%0d", i, op, sel), m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
